fizzbuzz_event_log: RTL and testbench
=====================================

// Module: fizzbuzz_event_log
// PURPOSE
//  Downstream consumer of the fizzbuzz counter stage. Samples fizz/buzz/fizzbuzz
//  on every in_valid cycle, classifies each sample into a 2-bit code, tags it with
//  a sample index, and buffers events in a FIFO drained over a valid/ready port.
//  Overflow is counted, never silent. Feeds the trace/scoreboard sink.
// PARAMETERS
//  DEPTH    8   FIFO entries; power of two, >=2
//  IDX_W    8   width of sample index tag; wraps modulo 2**IDX_W
//  DROP_W   8   width of dropped-event counter; saturates at all-ones
//  LOG_NONE 0   1: also log code 2'b00 samples; 0: discard them
// PORTS
//  clk        in   1      clock, all state on posedge
//  resetn     in   1      reset, asynchronous, active-low
//  in_valid   in   1      upstream sample strobe
//  fizz       in   1      upstream divisible-by-FIZZ flag
//  buzz       in   1      upstream divisible-by-BUZZ flag
//  fizzbuzz   in   1      upstream divisible-by-both flag
//  clear      in   1      sync flush: FIFO, index, drop count, overflow
//  out_valid  out  1      head entry available
//  out_ready  in   1      consumer accepts head
//  out_code   out  2      head code: 00 none, 01 fizz, 10 buzz, 11 fizzbuzz
//  out_index  out  IDX_W  head sample index
//  level      out  $clog2(DEPTH)+1  current FIFO occupancy
//  drop_cnt   out  DROP_W events dropped on full FIFO
//  overflow   out  1      sticky: >=1 drop since reset/clear
// BEHAVIOUR
//  - Reset (resetn=0, async): out_valid=0, level=0, drop_cnt=0, overflow=0,
//    index=0, out_code=0, out_index=0. Upstream drives flags=1 during reset; ignored.
//  - Code = {buzz|fizzbuzz, fizz|fizzbuzz}; fizzbuzz alone forces 11.
//  - Index counter increments on every in_valid cycle (logged or not), wraps to 0.
//    Entry tag = index value before the increment.
//  - Event = in_valid && (code!=0 || LOG_NONE). Push on event if not full, or if
//    full and a pop occurs same cycle (out_valid && out_ready).
//  - Event while full without pop: entry dropped, drop_cnt+1 (saturating),
//    overflow<=1. Index still increments.
//  - Pop = out_valid && out_ready. out_valid = (level!=0).
//  - Latency: event sampled at edge N appears at head (out_valid=1 if FIFO was
//    empty) immediately after edge N. No combinational in->out path.
//  - out_code/out_index stable while out_valid && !out_ready.
//  - Simultaneous push+pop: level unchanged, order preserved (FIFO strict order).
//  - Empty+pop impossible (out_valid=0). Level never exceeds DEPTH.
//  - clear=1: next edge level=0, index=0, drop_cnt=0, overflow=0; overrides
//    push/pop that cycle; the sample presented that cycle is discarded.
//  - resetn asserted mid-stream: all state cleared at once, in-flight entries lost.
// TESTING
//  1 FIZZ=3,BUZZ=5 upstream 0..15, out_ready=1 -> (code,idx): (11,0)(01,3)(10,5)
//    (01,6)(01,9)(10,10)(01,12)(11,15); drop_cnt=0.
//  2 DEPTH=4, out_ready=0, 6 events -> level=4, first 4 retained in order,
//    drop_cnt=2, overflow=1; then ready=1 drains exactly 4 entries.
//  3 FIFO full, event with out_ready=1 same cycle -> no drop, level stays 4,
//    new entry at tail, popped entry = oldest.
//  4 IDX_W=4, 20 in_valid samples, LOG_NONE=1 -> indices 0..15,0..3 in order.
//  5 out_valid=1, out_ready=0 held 5 cycles -> out_code/out_index unchanged;
//    drop_cnt saturates at 255 after 300 drops (DROP_W=8).
//  6 resetn=0 async mid-drain with level=3 -> out_valid=0, level=0 before next
//    edge; clear=1 with event same cycle -> level=0, index=0 afterwards.

Source files
------------

// File: rtl/fizzbuzz_event_log.sv
// fizzbuzz_event_log
//   Classifies each upstream fizzbuzz sample into a 2-bit code, tags it with a
//   running sample index, and queues events in a FIFO drained over valid/ready.
//   Events arriving while the FIFO is full and not popping are counted as drops.
// Ports
//   clk, resetn            clock, async active-low reset
//   in_valid               sample strobe
//   fizz, buzz, fizzbuzz   upstream flags
//   clear                  synchronous flush of FIFO, index, drop count, overflow
//   out_valid/out_ready    head handshake
//   out_code, out_index    head entry (zero while empty)
//   level                  FIFO occupancy
//   drop_cnt               saturating count of dropped events
//   overflow               sticky drop flag
module fizzbuzz_event_log #(
    parameter int DEPTH    = 8,
    parameter int IDX_W    = 8,
    parameter int DROP_W   = 8,
    parameter int LOG_NONE = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    input  logic                       fizz,
    input  logic                       buzz,
    input  logic                       fizzbuzz,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_code,
    output logic [IDX_W-1:0]           out_index,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0]       code;
        logic [IDX_W-1:0] idx;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [LW-1:0]     level_q;
    logic [IDX_W-1:0]  index_q;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;

    logic [1:0] code;
    logic       evt, full, pop, push, drop;

    // fizzbuzz sets both bits on its own, whatever fizz/buzz say
    assign code = {buzz | fizzbuzz, fizz | fizzbuzz};
    assign evt  = in_valid && ((code != 2'b00) || (LOG_NONE != 0));
    assign full = (level_q == LW'(DEPTH));
    assign pop  = out_valid && out_ready;
    // a same-cycle pop frees the slot, so a full FIFO can still accept
    assign push = evt && (!full || pop);
    assign drop = evt && full && !pop;

    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign drop_cnt  = drop_q;
    assign overflow  = ovf_q;
    assign out_code  = out_valid ? mem[rd_ptr].code : 2'b00;
    assign out_index = out_valid ? mem[rd_ptr].idx  : '0;

    // storage needs no reset; reads are masked by out_valid
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= '{code: code, idx: index_q};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            index_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            index_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // pointers wrap naturally: DEPTH is a power of two
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (in_valid) index_q <= index_q + IDX_W'(1);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fizzbuzz_event_log.sv
module tb_fizzbuzz_event_log;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // instance a: DEPTH=8, IDX_W=8, LOG_NONE=0
    logic       a_iv, a_f, a_b, a_fb, a_clr, a_ov, a_or, a_ovf;
    logic [1:0] a_code;
    logic [7:0] a_idx, a_drop;
    logic [3:0] a_lvl;

    fizzbuzz_event_log #(.DEPTH(8), .IDX_W(8), .DROP_W(8), .LOG_NONE(0)) u_a (
        .clk(clk), .resetn(resetn), .in_valid(a_iv), .fizz(a_f), .buzz(a_b),
        .fizzbuzz(a_fb), .clear(a_clr), .out_valid(a_ov), .out_ready(a_or),
        .out_code(a_code), .out_index(a_idx), .level(a_lvl), .drop_cnt(a_drop),
        .overflow(a_ovf));

    // instance b: DEPTH=4, IDX_W=4, LOG_NONE=1
    logic       b_iv, b_f, b_b, b_fb, b_clr, b_ov, b_or, b_ovf;
    logic [1:0] b_code;
    logic [3:0] b_idx;
    logic [7:0] b_drop;
    logic [2:0] b_lvl;

    fizzbuzz_event_log #(.DEPTH(4), .IDX_W(4), .DROP_W(8), .LOG_NONE(1)) u_b (
        .clk(clk), .resetn(resetn), .in_valid(b_iv), .fizz(b_f), .buzz(b_b),
        .fizzbuzz(b_fb), .clear(b_clr), .out_valid(b_ov), .out_ready(b_or),
        .out_code(b_code), .out_index(b_idx), .level(b_lvl), .drop_cnt(b_drop),
        .overflow(b_ovf));

    // popped entries, {code, index}
    logic [9:0] qa[$];
    logic [3:0] qb[$];
    always @(negedge clk) begin
        if (a_ov && a_or) qa.push_back({a_code, a_idx});
        if (b_ov && b_or) qb.push_back(b_idx);
    end

    task automatic a_set(input logic v, input logic f, input logic b, input logic fb);
        a_iv = v; a_f = f; a_b = b; a_fb = fb;
    endtask

    logic [9:0] exp1 [8];
    logic [1:0] hold_code;
    logic [7:0] hold_idx;

    initial begin
        exp1[0] = {2'b11, 8'd0};  exp1[1] = {2'b01, 8'd3};
        exp1[2] = {2'b10, 8'd5};  exp1[3] = {2'b01, 8'd6};
        exp1[4] = {2'b01, 8'd9};  exp1[5] = {2'b10, 8'd10};
        exp1[6] = {2'b01, 8'd12}; exp1[7] = {2'b11, 8'd15};

        // reset with upstream flags all high
        resetn = 1'b0;
        a_set(1, 1, 1, 1); a_clr = 0; a_or = 0;
        b_iv = 1; b_f = 1; b_b = 1; b_fb = 1; b_clr = 0; b_or = 0;
        tick(); tick();
        chk("rst_valid", 32'(a_ov), 0);
        chk("rst_level", 32'(a_lvl), 0);
        chk("rst_drop", 32'(a_drop), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_code", 32'(a_code), 0);
        chk("rst_idx", 32'(a_idx), 0);
        a_set(0, 0, 0, 0);
        b_iv = 0; b_f = 0; b_b = 0; b_fb = 0;
        resetn = 1'b1;
        tick();

        // 1: fizzbuzz stream 0..15 with FIZZ=3, BUZZ=5
        a_or = 1;
        for (int n = 0; n < 16; n++) begin
            a_set(1, (n % 3) == 0, (n % 5) == 0, (n % 15) == 0);
            tick();
        end
        a_set(0, 0, 0, 0);
        tick(); tick(); tick();
        chk("t1_count", 32'(qa.size()), 8);
        for (int i = 0; i < 8 && i < qa.size(); i++) chk($sformatf("t1_ev%0d", i), 32'(qa[i]), 32'(exp1[i]));
        chk("t1_drop", 32'(a_drop), 0);
        chk("t1_level", 32'(a_lvl), 0);

        // 5: hold stability, then drop saturation
        a_or = 0;
        a_clr = 1; tick(); a_clr = 0;
        a_set(1, 0, 1, 0); tick(); a_set(0, 0, 0, 0);
        chk("t5_head_valid", 32'(a_ov), 1);
        chk("t5_head_code", 32'(a_code), 2);
        chk("t5_head_idx", 32'(a_idx), 0);
        hold_code = a_code; hold_idx = a_idx;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t5_hold_code%0d", i), 32'(a_code), 32'(hold_code));
            chk($sformatf("t5_hold_idx%0d", i), 32'(a_idx), 32'(hold_idx));
        end
        a_set(1, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        chk("t5_full", 32'(a_lvl), 8);
        chk("t5_nodrop", 32'(a_drop), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_drop10", 32'(a_drop), 10);
        chk("t5_ovf", 32'(a_ovf), 1);
        for (int i = 0; i < 290; i++) tick();
        a_set(0, 0, 0, 0);
        chk("t5_drop_sat", 32'(a_drop), 255);
        chk("t5_level_cap", 32'(a_lvl), 8);

        // 6: async reset mid-drain, then clear vs. event
        a_clr = 1; tick(); a_clr = 0;
        a_set(1, 1, 0, 0);
        tick(); tick(); tick();
        a_set(0, 0, 0, 0);
        chk("t6_level3", 32'(a_lvl), 3);
        a_or = 1;
        #2 resetn = 1'b0;
        #1;
        chk("t6_async_valid", 32'(a_ov), 0);
        chk("t6_async_level", 32'(a_lvl), 0);
        #1 resetn = 1'b1;
        a_or = 0;
        tick();
        a_set(1, 1, 0, 0); tick(); tick();
        a_clr = 1; a_set(1, 0, 0, 1); tick();
        a_clr = 0; a_set(0, 0, 0, 0);
        chk("t6_clr_level", 32'(a_lvl), 0);
        chk("t6_clr_valid", 32'(a_ov), 0);
        a_set(1, 1, 0, 0); tick(); a_set(0, 0, 0, 0);
        chk("t6_clr_idx", 32'(a_idx), 0);
        chk("t6_clr_code", 32'(a_code), 1);

        // 2: DEPTH=4 overflow, ready low
        b_clr = 1; tick(); b_clr = 0;
        b_or = 0; b_iv = 1;
        for (int i = 0; i < 6; i++) tick();
        b_iv = 0;
        chk("t2_level", 32'(b_lvl), 4);
        chk("t2_drop", 32'(b_drop), 2);
        chk("t2_ovf", 32'(b_ovf), 1);
        b_or = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_valid%0d", i), 32'(b_ov), 1);
            chk($sformatf("t2_idx%0d", i), 32'(b_idx), i);
            tick();
        end
        chk("t2_empty", 32'(b_ov), 0);

        // 3: push into full FIFO while popping
        b_or = 0;
        b_clr = 1; tick(); b_clr = 0;
        b_iv = 1; b_f = 1;
        for (int i = 0; i < 4; i++) tick();
        b_f = 0; b_b = 1; b_or = 1;
        chk("t3_pop_oldest", 32'(b_idx), 0);
        tick();
        b_iv = 0; b_b = 0; b_or = 0;
        chk("t3_level", 32'(b_lvl), 4);
        chk("t3_nodrop", 32'(b_drop), 0);
        b_or = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_idx%0d", i), 32'(b_idx), i + 1);
            chk($sformatf("t3_code%0d", i), 32'(b_code), (i == 3) ? 2 : 1);
            tick();
        end
        chk("t3_empty", 32'(b_ov), 0);

        // 4: IDX_W=4 wrap with LOG_NONE=1
        b_clr = 1; tick(); b_clr = 0;
        qb.delete();
        b_iv = 1;
        for (int i = 0; i < 20; i++) tick();
        b_iv = 0;
        tick(); tick(); tick();
        chk("t4_count", 32'(qb.size()), 20);
        for (int i = 0; i < 20 && i < qb.size(); i++) chk($sformatf("t4_idx%0d", i), 32'(qb[i]), i % 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
